// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-style LCD receiver.
//   - nibble assembly FSM state type
//   - display geometry (ROWS x COLS) and the blank character
//   - bit positions of the instruction set, highest set bit selects the command
package lcd_pkg;

  localparam int ROWS  = 2;
  localparam int COLS  = 16;
  localparam int DEPTH = ROWS * COLS;

  localparam logic [7:0] SPACE = 8'h20;

  // Command class = position of the highest set bit of the instruction byte
  localparam int CMD_DDRAM = 7;
  localparam int CMD_CGRAM = 6;
  localparam int CMD_FUNC  = 5;
  localparam int CMD_DISP  = 3;
  localparam int CMD_ENTRY = 2;
  localparam int CMD_HOME  = 1;
  localparam int CMD_CLEAR = 0;

  // Argument bits inside the commands
  localparam int FUNC_DL  = 4;  // 1 = 8-bit interface
  localparam int DISP_D   = 2;  // display on
  localparam int ENTRY_ID = 1;  // 1 = increment

  typedef enum logic {
    ST_HI = 1'b0,
    ST_LO = 1'b1
  } nib_state_t;

endpackage

// File: rtl/lcd_sync.sv
// lcd_sync: brings the asynchronous LCD bus into the clk domain.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   lcd_e, lcd_rs, lcd_rw, lcd_d : raw LCD bus (asynchronous)
//   e_fall                       : one-cycle strobe on the falling edge of lcd_e
//   rs_smp, rw_smp, d_smp        : bus values from the cycle before the edge
module lcd_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_d,
  output logic       e_fall,
  output logic       rs_smp,
  output logic       rw_smp,
  output logic [3:0] d_smp
);

  // Bus packed as {e, rs, rw, d[3:0]}
  logic [6:0] meta_p0;
  logic [6:0] sync_p1;
  logic [6:0] prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      meta_p0 <= {lcd_e, lcd_rs, lcd_rw, lcd_d};
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  // prev_p2 holds the last synchronized values while e was still high, so the
  // writer's data is taken from before the falling edge.
  assign e_fall = prev_p2[6] & ~sync_p1[6];
  assign rs_smp = prev_p2[5];
  assign rw_smp = prev_p2[4];
  assign d_smp  = prev_p2[3:0];

endmodule

// File: rtl/lcd_rx.sv
// lcd_rx: passive HD44780 bus receiver with a 2x16 character shadow memory.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   lcd_e, lcd_rs, lcd_rw, lcd_d : LCD writer bus (D7..D4 only)
//   rd_addr / rd_data            : display memory read port, 1-cycle latency
//   byte_valid, byte_rs, byte_data : pulse + contents of each completed byte
//   cursor                       : DDRAM address {row, col}
//   mode4, disp_on, busy         : interface width, display-on, clear running
//   rx_err                       : one-cycle protocol error pulse
module lcd_rx
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_d,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic [4:0] cursor,
  output logic       mode4,
  output logic       disp_on,
  output logic       busy,
  output logic       rx_err
);

  logic       e_fall;
  logic       rs_smp;
  logic       rw_smp;
  logic [3:0] d_smp;

  lcd_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_d  (lcd_d),
    .e_fall (e_fall),
    .rs_smp (rs_smp),
    .rw_smp (rw_smp),
    .d_smp  (d_smp)
  );

  nib_state_t state, state_nxt;
  logic       inc;
  logic [4:0] clr_cnt;
  logic [3:0] hi_nib;
  logic       hi_rs;

  logic       done;
  logic       cap_hi;
  logic       asm_err;
  logic       asm_rs;
  logic [7:0] asm_byte;

  logic       ddram_ok;
  logic [4:0] ddram_addr;
  logic [3:0] col_step;

  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] mem [DEPTH];

  // ---- strobe -> byte assembly ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HI;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    cap_hi    = 1'b0;
    asm_err   = 1'b0;
    asm_rs    = rs_smp;
    asm_byte  = {d_smp, 4'h0};
    if (e_fall) begin
      if (rw_smp) begin
        asm_err = 1'b1;
      end else if (!mode4) begin
        done = 1'b1;
      end else if (state == ST_HI) begin
        cap_hi    = 1'b1;
        state_nxt = ST_LO;
      end else begin
        state_nxt = ST_HI;
        asm_byte  = {hi_nib, d_smp};
        if (rs_smp != hi_rs) asm_err = 1'b1;
        else                 done    = 1'b1;
      end
    end
    // A function set resynchronises the nibble phase.
    if (done && !busy && !asm_rs && asm_byte[7:5] == 3'b001) state_nxt = ST_HI;
  end

  always_ff @(posedge clk) begin
    if (cap_hi) begin
      hi_nib <= d_smp;
      hi_rs  <= rs_smp;
    end
  end

  // ---- byte execution ----
  // Only DDRAM addresses 0x00-0x0F and 0x40-0x4F exist on a 2x16 panel.
  always_comb begin
    ddram_ok   = (asm_byte[6:4] == 3'b000) || (asm_byte[6:4] == 3'b100);
    ddram_addr = {asm_byte[6], asm_byte[3:0]};
    col_step   = inc ? cursor[3:0] + 4'd1 : cursor[3:0] - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode4      <= 1'b0;
      cursor     <= '0;
      inc        <= 1'b1;
      disp_on    <= 1'b0;
      busy       <= 1'b0;
      clr_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_rs    <= 1'b0;
      byte_data  <= '0;
      rx_err     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      rx_err     <= asm_err;
      if (busy) begin
        clr_cnt <= clr_cnt + 5'd1;
        if (clr_cnt == 5'(DEPTH - 1)) busy <= 1'b0;
      end
      if (done) begin
        if (busy) begin
          rx_err <= 1'b1;
        end else begin
          byte_valid <= 1'b1;
          byte_rs    <= asm_rs;
          byte_data  <= asm_byte;
          if (asm_rs) begin
            cursor <= {cursor[4], col_step};
          end else if (asm_byte[CMD_DDRAM]) begin
            if (ddram_ok) cursor <= ddram_addr;
            else          rx_err <= 1'b1;
          end else if (!asm_byte[CMD_CGRAM]) begin
            if (asm_byte[CMD_FUNC]) begin
              mode4 <= ~asm_byte[FUNC_DL];
            end else if (asm_byte[CMD_DISP]) begin
              disp_on <= asm_byte[DISP_D];
            end else if (asm_byte[CMD_ENTRY]) begin
              inc <= asm_byte[ENTRY_ID];
            end else if (asm_byte[CMD_HOME]) begin
              cursor <= '0;
            end else if (asm_byte[CMD_CLEAR]) begin
              cursor  <= '0;
              busy    <= 1'b1;
              clr_cnt <= '0;
            end
          end
        end
      end
    end
  end

  // ---- display memory ----
  // Clear sweeps one entry per cycle; data writes are refused while busy, so
  // the two write sources never collide.
  always_comb begin
    wr_en   = busy | (done & asm_rs);
    wr_addr = busy ? clr_cnt : cursor;
    wr_data = busy ? SPACE : asm_byte;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: doc/lcd_rx.md
LCD_RX -- requirements
Module: lcd_rx

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 lcd_e  in  1  HD44780 enable strobe from the LCD writer; asynchronous to clk.
REQ-005 lcd_rs  in  1  register select: 0 command, 1 data.
REQ-006 lcd_rw  in  1  read/write: 0 write, 1 read (unsupported).
REQ-007 lcd_d  in  4  data bus upper nibble, D7..D4.
REQ-008 rd_addr  in  5  display-memory read address {row, col[3:0]}.
REQ-009 rd_data  out  8  character at rd_addr.
REQ-010 byte_valid  out  1  one-cycle pulse for each completed byte.
REQ-011 byte_rs  out  1  rs of the completed byte.
REQ-012 byte_data  out  8  the completed byte.
REQ-013 cursor  out  5  current DDRAM address {row, col}.
REQ-014 mode4  out  1  1 = 4-bit interface active.
REQ-015 disp_on  out  1  display-on bit (D) from the display-control command.
REQ-016 busy  out  1  high while a clear is in progress.
REQ-017 rx_err  out  1  one-cycle error pulse.

Function
REQ-018 SHALL pass lcd_e, lcd_rs, lcd_rw and lcd_d through 2-flop synchronizers.
REQ-019 SHALL detect the falling edge of synchronized lcd_e as a strobe; rs, rw and d are sampled from the synchronized values one cycle before the edge.
REQ-020 Strobe with rw=1 SHALL be ignored except for a rx_err pulse.
REQ-021 In 8-bit mode (mode4=0), each strobe SHALL form byte {d,4'h0}.
REQ-022 In 4-bit mode, a strobe SHALL be handled by FSM state HI (store high nibble and rs) or LO (complete the byte); HI→LO→HI.
REQ-023 If rs at LO differs from rs stored at HI: pulse rx_err; discard the byte; return to HI.
REQ-024 byte_valid SHALL assert on the cycle after the strobe that completes a byte; latency from the lcd_e fall to byte_valid is 4 clk max.
REQ-025 Command decode, rs=0, priority from highest set bit:
- 1xxxxxxx set DDRAM: addr 0x00-0x0F → row0; 0x40-0x4F → row1; otherwise cursor unchanged and rx_err.
- 001xxxxx function set: mode4 <= ~bit4; the FSM enters HI.
- 00001xxx: disp_on <= bit2.
- 000001xx: increment flag <= bit1.
- 0000001x: cursor <= 0.
- 00000001 clear: cursor <= 0; fill all 32 entries with 0x20, one per cycle; busy is high for 32 cycles.
REQ-026 Data write, rs=1: mem[cursor] <= byte; the column increments or decrements modulo 16; row unchanged.
REQ-027 Any byte completing while busy=1 SHALL be dropped, with rx_err; the clear continues.
REQ-028 rd_data SHALL be registered with 1-cycle latency; a same-cycle read and write to one address returns the old value.
REQ-029 Strobes closer than 2 clk apart are outside the supported input range.

Reset
REQ-030 rst_n low SHALL force: mode4=0; FSM in HI; cursor=0; increment flag=1; disp_on=0; busy=0; byte_valid=0; rx_err=0; byte_data=0; byte_rs=0; synchronizers=0.
REQ-031 Display memory content is undefined after reset until the first clear.
REQ-032 Reset mid-byte or mid-clear SHALL abandon the operation; the next strobe is treated as 8-bit mode.

Structure
REQ-033 Shared package lcd_pkg SHALL hold:
- FSM state enum;
- command bit positions;
- ROWS=2, COLS=16;
- SPACE=8'h20.
REQ-034 Sub-module lcd_sync SHALL contain the 2-flop synchronizer and the lcd_e falling-edge detector.

Verification
REQ-035 After reset, send nibbles 2,2,8,0,C,0,1,0,6 with rs=0. Required: mode4=1, disp_on=1, busy high 32 cycles, then all rd_data=0x20, cursor=0.
REQ-036 After REQ-035, send rs=1 nibbles 4,1. Required: byte_valid with 0x41, mem[0]=0x41, cursor=1.
REQ-037 Write 17 data bytes from cursor 0. Required: the 17th byte lands at address 0, cursor=1, row1 entries still 0x20.
REQ-038 Send command 0xC0, then data 0x5A. Required: mem[16]=0x5A, cursor=17.
REQ-039 Send high nibble with rs=1, low nibble with rs=0. Required: rx_err pulse, no byte_valid, memory unchanged.
REQ-040 Pulse rst_n after one nibble in 4-bit mode. Required: mode4=0, and the next strobe with d=3 yields byte_valid 0x30.
